disp_arbiter: RTL
=================

Name: disp_arbiter

Overview:
- Shares the 4-digit 7-segment display between NREQ requesters, e.g. program selector, monitor status and keyboard echo.
- Each requester posts a 32-bit pattern; the winner owns the display for a fixed hold time, then the display returns to the idle pattern.
- Contains the digit scan/multiplex driver and sits between the system logic and the board seg/an/dp pins.
- Pattern format per digit byte: bit 7 = dp, bits 6:0 = seg, active-low. Byte 0 = digit 0 (an[0]) … byte 3 = digit 3 (an[3]).

Parameters:
- NREQ, 4, number of requesters (2..8).
- TICK_DIV, 100000, clk cycles per hold tick (1 ms at 100 MHz).
- HOLD_TICKS, 1000, ticks a granted pattern stays displayed.
- SCAN_BITS, 18, scan counter LSB width; digit period = 2^SCAN_BITS clk.
- BLINK_TICKS, 250, ticks per blink half-period (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- req  in  NREQ  level request per requester.
- pat_in  in  32*NREQ  patterns; requester i uses bits [32*i+31:32*i].
- idle_pat  in  32  pattern shown when nobody owns the display.
- grant  out  NREQ  one-cycle pulse: requester i's pattern was latched.
- busy  out  1  high while a requester owns the display.
- owner  out  3  index of the current owner; 0 when idle.
- seg  out  7  segment outputs, active-low.
- dp  out  1  decimal point, active-low.
- an  out  4  digit anodes, active-low, one-hot-low.

Behaviour:
- Reset values: state=IDLE, grant=0, busy=0, owner=0, seg=7'h7F, dp=1, an=4'hF; all counters 0; latched pattern = 32'hFFFF_FFFF.
- Priority: fixed, lowest index wins.

FSM, state IDLE:
- Displayed pattern = idle_pat, sampled live.
- If any req is high: latch the winner's pattern, pulse grant[w], owner<=w, hold<=HOLD_TICKS, clear the tick prescaler, go to SHOW.
- The grant pulse occurs in the cycle after req is sampled.

FSM, state SHOW:
- Displayed pattern = latched pattern; busy=1.
- The tick prescaler counts 0..TICK_DIV-1. On wrap, hold decrements.
- When hold reaches 0 on a tick, go to IDLE. busy/owner clear in the same cycle, with no gap cycle.

Preemption and re-requests in SHOW:
- req[j] with j<owner: immediate re-latch exactly as from IDLE; grant[j] pulses and hold reloads.
- req[owner] still high: no re-grant. The pattern is frozen until hold expires. On expiry, return to IDLE; a still-high request is re-granted on the next cycle.
- req[j] with j>owner is ignored until the display is released.
- Expiry and preemption in the same cycle: preemption wins; stay in SHOW.

Widths and counters:
- The hold counter is sized by $clog2(HOLD_TICKS+1). HOLD_TICKS=0 is illegal.
- Scan counter: SCAN_BITS+2 bits, free-running, wraps. s = top 2 bits.
- seg/dp/an are all registered from s and the displayed pattern: 1 cycle latency, glitch-free.
- an[s]=0 with all other bits 1. seg/dp = byte s of the displayed pattern.

Reset mid-operation: all state returns to reset values asynchronously; no grant pulse is emitted.

Optional Feature:
- Macro: DISP_ARB_BLINK_EN.
- Defined:
  - A blink phase bit toggles every BLINK_TICKS ticks while in SHOW, and clears on every grant.
  - When phase=1, an is forced to 4'hF, blanking the display. Idle display never blinks.
  - Hold timing is unaffected.
- Undefined: no blink logic is synthesised and the SHOW display is steady; BLINK_TICKS is ignored.

Decomposition:
- Shared package disp_pkg:
  - FSM state enum (IDLE, SHOW);
  - PAT_BLANK = 32'hFFFF_FFFF;
  - PAT_8888 = 32'h8080_8080;
  - digit byte index constants.
- One natural sub-module, seg_scan:
  - inputs: clk, rst, the 32-bit pattern and a blank input;
  - owns the scan counter and the registered seg/dp/an.
- disp_arbiter keeps the FSM, prescaler, hold counter, priority encoder and blink logic.

Test Plan (TICK_DIV=4, HOLD_TICKS=3, SCAN_BITS=2):
- Reset with idle_pat=32'h8080_8080: a scan cycle shows an=1110/1101/1011/0111 each with seg=7'h00, dp=1. busy=0, grant=0.
- req[2]=1 with pat2=32'h4079_2430: grant[2] pulses one cycle later, owner=2, busy high for exactly 12 clk, then the display returns to idle_pat.
- req[1] and req[3] raised in the same cycle: grant[1] only; owner=1; pat3 is never shown.
- During SHOW with owner=2, raise req[0]: grant[0] pulses next cycle and hold reloads (busy lasts 12 clk from the preemption). req[3] raised during SHOW gets no grant until release.
- Assert rst mid-SHOW: outputs go to seg=7'h7F, an=4'hF, busy=0 immediately. After release, a still-high req is re-granted.
- With DISP_ARB_BLINK_EN and BLINK_TICKS=1: an=4'hF in alternating 4-clk windows during SHOW, never during IDLE. Without the macro, an is never all-high after reset.

Source files
------------

// File: rtl/disp_arbiter_pkg.sv
// Shared types and constants for the display arbiter and its digit scanner.
package disp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  localparam logic [31:0] PAT_BLANK = 32'hFFFF_FFFF;
  localparam logic [31:0] PAT_8888  = 32'h8080_8080;

  localparam int DIG0 = 0;
  localparam int DIG1 = 1;
  localparam int DIG2 = 2;
  localparam int DIG3 = 3;

  // Byte idx of a pattern: bit 7 = dp, bits 6:0 = seg, all active-low.
  function automatic logic [7:0] pat_byte(input logic [31:0] p, input logic [1:0] idx);
    return p[8*idx +: 8];
  endfunction

endpackage

// File: rtl/disp_arbiter_if.sv
// Requester-side bus of the display arbiter: requests, patterns, grant/ownership status.
interface disp_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]      req;
  logic [32*NREQ-1:0]   pat_in;
  logic [31:0]          idle_pat;
  logic [NREQ-1:0]      grant;
  logic                 busy;
  logic [2:0]           owner;

  modport master (output req, pat_in, idle_pat, input grant, busy, owner);
  modport slave  (input req, pat_in, idle_pat, output grant, busy, owner);
endinterface

// File: rtl/disp_arbiter_seg_scan.sv
// Free-running 4-digit multiplexer; seg/dp/an are registered for glitch-free pins.
module seg_scan
  import disp_pkg::*;
#(
  parameter int SCAN_BITS = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pat,
  input  logic        blank,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  logic [SCAN_BITS+1:0] scan_cnt;
  logic [1:0]           s;
  logic [7:0]           cur;
  logic [3:0]           an_sel;

  assign s      = scan_cnt[SCAN_BITS+1 -: 2];
  assign cur    = pat_byte(pat, s);
  assign an_sel = ~(4'b0001 << s);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      seg      <= 7'h7F;
      dp       <= 1'b1;
      an       <= 4'hF;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
      seg      <= cur[6:0];
      dp       <= cur[7];
      an       <= blank ? 4'hF : an_sel;
    end
  end

endmodule

// File: rtl/disp_arbiter.sv
// Fixed-priority owner of the 7-segment display with timed hold and digit scan.
// Optional blinking of owned patterns is enabled with DISP_ARB_BLINK_EN.
//
// state | meaning
// IDLE  | nobody owns the display, idle_pat shown live
// SHOW  | latched pattern of owner shown until hold expires or a lower index preempts
module disp_arbiter
  import disp_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int TICK_DIV    = 100000,
  parameter int HOLD_TICKS  = 1000,
  parameter int SCAN_BITS   = 18,
  parameter int BLINK_TICKS = 250
) (
  input  logic           clk,
  input  logic           rst,
  disp_arbiter_if.slave  bus,
  output logic [6:0]     seg,
  output logic           dp,
  output logic [3:0]     an
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = $clog2(HOLD_TICKS + 1);

  if (NREQ < 2 || NREQ > 8 || TICK_DIV < 1 || HOLD_TICKS < 1 || BLINK_TICKS < 1) begin : g_param_check
    $error("disp_arbiter: illegal parameter value");
  end

  state_t          state, state_nx;
  logic [PW-1:0]   presc;
  logic [HW-1:0]   hold;
  logic [31:0]     pat_lat, win_pat, disp_pat;
  logic [NREQ-1:0] grant_q;
  logic [2:0]      owner_q, win_idx;
  logic            win_valid, load, tick, expire, show, blank;

  always_comb begin
    win_valid = |bus.req;
    win_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[i]) win_idx = 3'(i);
    end
  end

  assign win_pat = bus.pat_in[32*int'(win_idx) +: 32];
  assign tick    = (presc == PW'(TICK_DIV - 1));
  assign expire  = tick && (hold == HW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Preemption by a lower index takes precedence over expiry in the same cycle.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    unique case (state)
      IDLE: begin
        if (win_valid) begin
          load     = 1'b1;
          state_nx = SHOW;
        end
      end
      SHOW: begin
        if (win_valid && (win_idx < owner_q)) load = 1'b1;
        else if (expire)                      state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    show     = (state == SHOW);
    disp_pat = show ? pat_lat : bus.idle_pat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q <= '0;
      owner_q <= '0;
      pat_lat <= PAT_BLANK;
      hold    <= '0;
      presc   <= '0;
    end else begin
      grant_q <= '0;
      if (load) begin
        grant_q <= NREQ'(1) << win_idx;
        pat_lat <= win_pat;
        owner_q <= win_idx;
        hold    <= HW'(HOLD_TICKS);
        presc   <= '0;
      end else if (show) begin
        presc <= tick ? '0 : presc + PW'(1);
        if (tick)   hold    <= hold - HW'(1);
        if (expire) owner_q <= '0;
      end
    end
  end

`ifdef DISP_ARB_BLINK_EN
  localparam int BW = $clog2(BLINK_TICKS + 1);

  logic [BW-1:0] blink_cnt;
  logic          phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (load) begin
      blink_cnt <= BW'(BLINK_TICKS - 1);
      phase     <= 1'b0;
    end else if (show && tick) begin
      if (blink_cnt == '0) begin
        phase     <= ~phase;
        blink_cnt <= BW'(BLINK_TICKS - 1);
      end else begin
        blink_cnt <= blink_cnt - BW'(1);
      end
    end
  end

  // Phase may linger after release; gating with show keeps the idle display steady.
  assign blank = show && phase;
`else
  assign blank = 1'b0;
`endif

  assign bus.grant = grant_q;
  assign bus.owner = owner_q;
  assign bus.busy  = show;

  seg_scan #(
    .SCAN_BITS (SCAN_BITS)
  ) u_seg_scan (
    .clk   (clk),
    .rst   (rst),
    .pat   (disp_pat),
    .blank (blank),
    .seg   (seg),
    .dp    (dp),
    .an    (an)
  );

endmodule
